fifo_drain_ctrl: RTL and testbench

Read-side controller for the 8x9 FIFO storage block. It tracks occupancy by observing the writer's strobe and issues rden pulses whenever the FIFO holds data. It captures the registered read data and presents each word downstream on a valid/ready handshake. It also sequences the read- and write-pointer clears for a flush, and flags writes that arrive while the FIFO is full.

---
 rtl/fifo_drain_ctrl_if.sv | 21 ++
 rtl/fifo_drain_ctrl.sv | 123 ++++++++++++
 tb/tb_fifo_drain_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_drain_ctrl_if.sv
// Downstream word stream of the FIFO drain controller: data/valid toward the
// consumer, ready back from it.
interface fifo_drain_ctrl_if #(
  parameter int WIDTH = 9
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// Read-side controller for the 8x9 FIFO: tracks occupancy from the writer's
// strobe, issues rden, presents each word on valid/ready, and sequences flushes.
module fifo_drain_ctrl #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 wr_strobe,
  input  logic [WIDTH-1:0]     fifo_dout,
  output logic                 rden,
  output logic                 rd_ptr_clr,
  output logic                 wr_ptr_clr,
  fifo_drain_ctrl_if.master    down,
  output logic [CNT_W-1:0]     count,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow
);

  if ($clog2(DEPTH + 1) > CNT_W) begin : g_cnt_w_check
    $error("CNT_W too narrow to hold 0..DEPTH");
  end

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPTURE,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             handshake;
  logic             wr_accept;
  logic             wr_overflow;
  logic [CNT_W-1:0] count_nxt;

  assign down.out_valid = out_valid_q;
  assign down.out_data  = out_data_q;

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can leave
    // it unassigned and infer a latch.
    handshake   = out_valid_q && down.out_ready;
    // A write at full is still taken when a read frees a slot the same cycle.
    wr_accept   = wr_strobe && (!full || rden);
    wr_overflow = wr_strobe && full && !rden;
    count_nxt   = count;
    if (flush) begin
      count_nxt = '0;
    end else if (wr_accept && !rden) begin
      count_nxt = count + ONE_C;
    end else if (!wr_accept && rden) begin
      count_nxt = count - ONE_C;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (count != '0) state_nxt = READ;
      READ:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = HOLD;
      // count already excludes the held word: it was taken off at its rden.
      HOLD:    if (handshake) state_nxt = (count != '0) ? READ : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Outputs are decoded from the next state so they are registered yet line up
  // with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rden        <= 1'b0;
      rd_ptr_clr  <= 1'b0;
      wr_ptr_clr  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      rden        <= (state_nxt == READ);
      rd_ptr_clr  <= flush;
      wr_ptr_clr  <= flush;
      out_valid_q <= (state_nxt == HOLD);
      if (state == CAPTURE && !flush) out_data_q <= fifo_dout;
      count       <= count_nxt;
      empty       <= (count_nxt == '0);
      full        <= (count_nxt == DEPTH_C);
      if (flush)            overflow <= 1'b0;
      else if (wr_overflow) overflow <= 1'b1;
    end
  end

  a_no_read_when_empty : assert property (
    @(posedge clk) disable iff (rst) rden |-> (count != '0));

  a_hold_stable : assert property (
    @(posedge clk) disable iff (rst)
    (out_valid_q && !down.out_ready && !flush) |=> (out_valid_q && $stable(out_data_q)));

  a_flags_exclusive : assert property (
    @(posedge clk) disable iff (rst) !(empty && full));

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Randomised and directed bench for fifo_drain_ctrl, with a behavioural FIFO on
// the read port and a transaction-level reference model of the drain engine.
module tb_fifo_drain_ctrl;

  localparam int DEPTH = 8;
  localparam int WIDTH = 9;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             wr_strobe = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic [WIDTH-1:0] fifo_dout;
  logic             rden, rd_ptr_clr, wr_ptr_clr;
  logic [CNT_W-1:0] count;
  logic             empty, full, overflow;

  fifo_drain_ctrl_if #(.WIDTH(WIDTH)) down ();

  fifo_drain_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .wr_strobe  (wr_strobe),
    .fifo_dout  (fifo_dout),
    .rden       (rden),
    .rd_ptr_clr (rd_ptr_clr),
    .wr_ptr_clr (wr_ptr_clr),
    .down       (down.master),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Behavioural 8x9 storage block driven by the writer and by the DUT's strobes.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [2:0]       wptr, rptr;
  int               env_occ;
  logic             env_wr;

  assign env_wr = wr_strobe && (env_occ < DEPTH || rden);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      env_occ   <= 0;
      fifo_dout <= '0;
    end else begin
      if (rden) fifo_dout <= mem[rptr];
      if (rd_ptr_clr)  rptr <= '0;
      else if (rden)   rptr <= rptr + 3'd1;
      if (wr_ptr_clr) begin
        wptr    <= '0;
        env_occ <= 0;
      end else begin
        if (env_wr) begin
          mem[wptr] <= wdata;
          wptr      <= wptr + 3'd1;
        end
        env_occ <= env_occ + (env_wr ? 1 : 0) - (rden ? 1 : 0);
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: occupancy, a queue of stored words, and the age of the
  // word currently owned by the drain engine (-1 none, 0 read, 1 capture, 2 shown).
  int               m_count;
  bit               m_ovf, m_rden, m_valid, m_clr;
  logic [WIDTH-1:0] m_data, m_word;
  int               m_age;
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] got[$];
  bit               last_f;

  task automatic model_reset();
    m_count = 0; m_ovf = 0; m_rden = 0; m_valid = 0; m_clr = 0;
    m_data = '0; m_word = '0; m_age = -1; m_q.delete(); last_f = 0;
  endtask

  task automatic model_advance(input bit f, input bit w, input logic [WIDTH-1:0] d, input bit r);
    bit hs, acc, nxt_rden;
    int age_n;
    if (f) begin
      m_count = 0; m_ovf = 0; m_rden = 0; m_valid = 0; m_clr = 1;
      m_age = -1; m_q.delete();
      return;
    end
    hs  = m_valid && r;
    acc = w && (m_count < DEPTH || m_rden);
    if (w && m_count == DEPTH && !m_rden) m_ovf = 1;
    nxt_rden = (m_age == -1 || hs) && m_count > 0;
    if (m_age == -1 || hs) age_n = nxt_rden ? 0 : -1;
    else                   age_n = (m_age < 2) ? m_age + 1 : 2;
    if (m_age == 1) m_data = m_word;
    if (acc) m_q.push_back(d);
    if (nxt_rden && m_q.size() > 0) m_word = m_q.pop_front();
    m_count = m_count + (acc ? 1 : 0) - (m_rden ? 1 : 0);
    m_rden  = nxt_rden;
    m_age   = age_n;
    m_valid = (age_n == 2);
    m_clr   = 0;
  endtask

  task automatic compare();
    check("count", 32'(count), 32'(m_count));
    check("empty", 32'(empty), 32'(m_count == 0));
    check("full", 32'(full), 32'(m_count == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("rden", 32'(rden), 32'(m_rden));
    check("out_valid", 32'(down.out_valid), 32'(m_valid));
    check("out_data", 32'(down.out_data), 32'(m_data));
    check("rd_ptr_clr", 32'(rd_ptr_clr), 32'(m_clr));
    check("wr_ptr_clr", 32'(wr_ptr_clr), 32'(m_clr));
  endtask

  // One cycle: check registered outputs, then drive this cycle's inputs.
  task automatic step(input bit f, input bit w, input logic [WIDTH-1:0] d, input bit r);
    @(negedge clk);
    compare();
    if (down.out_valid && r) got.push_back(down.out_data);
    flush = f; wr_strobe = w; wdata = d; down.out_ready = r;
    model_advance(f, w, d, r);
    last_f = f;
  endtask

  task automatic do_reset();
    flush = 0; wr_strobe = 0; down.out_ready = 0; rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    compare();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int wr_pct, rd_pct;
    bit f, w, r;
    down.out_ready = 1'b0;

    // 1: three words drain in order
    do_reset();
    got.delete();
    step(0, 1, 9'h101, 1);
    step(0, 1, 9'h0A5, 1);
    step(0, 1, 9'h1FF, 1);
    repeat (15) step(0, 0, '0, 1);
    check("t1_n_words", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      check("t1_word0", 32'(got[0]), 32'h101);
      check("t1_word1", 32'(got[1]), 32'h0A5);
      check("t1_word2", 32'(got[2]), 32'h1FF);
    end
    check("t1_empty", 32'(empty), 32'd1);

    // 2: fill to full with no consumer, then overflow
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 1, 9'($urandom), 0);
    repeat (3) step(0, 0, '0, 0);
    check("t2_full", 32'(full), 32'd1);
    check("t2_overflow", 32'(overflow), 32'd1);

    // 3: one word held while the consumer stalls
    do_reset();
    step(0, 1, 9'h15A, 0);
    repeat (8) step(0, 0, '0, 0);
    check("t3_hold_data", 32'(down.out_data), 32'h15A);
    step(0, 0, '0, 1);
    repeat (3) step(0, 0, '0, 0);

    // 4: write coincident with rden at count 1
    do_reset();
    step(0, 1, 9'h011, 1);
    step(0, 0, '0, 1);
    step(0, 1, 9'h022, 1);
    repeat (10) step(0, 0, '0, 1);

    // 5: flush while holding a word with overflow set
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 1, 9'($urandom), 0);
    repeat (10) step(0, 0, '0, 1);
    repeat (3) step(0, 0, '0, 0);
    step(1, 1, 9'h1AB, 0);
    step(0, 0, '0, 0);
    check("t5_rd_clr", 32'(rd_ptr_clr), 32'd1);
    check("t5_count", 32'(count), 32'd0);
    check("t5_overflow", 32'(overflow), 32'd0);
    repeat (6) step(0, 0, '0, 1);

    // 6: asynchronous reset during a read
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 9'($urandom), 1);
    for (int i = 0; i < 10 && !m_rden; i++) step(0, 0, '0, 1);
    check("t6_reached_read", 32'(m_rden), 32'd1);
    @(posedge clk);
    #1;
    check("t6_pre_rden", 32'(rden), 32'(m_rden));
    #1;
    rst = 1;
    #1;
    check("t6_rden", 32'(rden), 32'd0);
    check("t6_count", 32'(count), 32'd0);
    check("t6_valid", 32'(down.out_valid), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    flush = 0; wr_strobe = 0; down.out_ready = 0;
    @(negedge clk);
    rst = 0;
    model_reset();

    // Random traffic with flushes and shifting write/read pressure
    wr_pct = 50;
    rd_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        wr_pct = $urandom_range(10, 90);
        rd_pct = $urandom_range(10, 90);
      end
      f = ($urandom_range(0, 49) == 0) || (last_f && $urandom_range(0, 2) == 0);
      w = !last_f && ($urandom_range(0, 99) < wr_pct);
      r = $urandom_range(0, 99) < rd_pct;
      step(f, w, 9'($urandom), r);
    end
    step(0, 0, '0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
